fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n  input  1  asynchronous reset, active-high despite the name; clears all state immediately when 1.
REQ-003 SHALL have port hazard  input  1  downstream stall; presented instruction not consumed this edge.
REQ-004 SHALL have port IF_flush  input  1  redirect request, sampled on rising edge.
REQ-005 SHALL have port redirect_pc  input  WORD_SIZE  new fetch address used with IF_flush.
REQ-006 SHALL have port o_readM  output  1  instruction memory read request.
REQ-007 SHALL have port o_addr  output  WORD_SIZE  instruction memory address, equals internal PC.
REQ-008 SHALL have port i_mem_ready  input  1  memory returns data this cycle; meaningful only while o_readM=1.
REQ-009 SHALL have port i_mem_data  input  WORD_SIZE  returned instruction word.
REQ-010 SHALL have port o_pc  output  WORD_SIZE  fetch address of presented instruction plus 1 (feeds IF_ID i_pc).
REQ-011 SHALL have port o_Idata  output  WORD_SIZE  presented instruction (feeds IF_ID i_Idata).
REQ-012 SHALL have port o_valid  output  1  o_Idata/o_pc hold a real instruction; 0 = bubble.

Function
REQ-013 SHALL implement states REQ, HOLD, RESTART; all outputs registered except o_readM/o_addr, decoded from state and PC.
REQ-014 SHALL drive o_readM=1 only in REQ; o_readM=0 in HOLD and RESTART.
REQ-015 SHALL treat the presented instruction as consumed on any rising edge with hazard=0.
REQ-016 In REQ with i_mem_ready=1 and output free (o_valid=0 or hazard=0): SHALL load o_Idata<=i_mem_data, o_pc<=PC+1, o_valid<=1, PC<=PC+1, stay REQ; back-to-back fetch, one instruction per cycle when memory ready every cycle.
REQ-017 In REQ with i_mem_ready=1 and output occupied (o_valid=1, hazard=1): SHALL capture data and PC+1 into a one-entry skid buffer, PC<=PC+1, go HOLD.
REQ-018 In REQ with i_mem_ready=0 and output consumed: SHALL clear o_valid to 0 (bubble).
REQ-019 In HOLD with hazard=0: SHALL move skid buffer to outputs, o_valid=1, go REQ; with hazard=1 stay HOLD, outputs unchanged.
REQ-020 IF_flush=1 at an edge SHALL take priority over hazard and i_mem_ready: PC<=redirect_pc, o_valid<=0, skid discarded, returned data ignored, go RESTART.
REQ-021 RESTART SHALL last exactly one cycle (o_readM=0, aborting any in-flight request) then go REQ, unless IF_flush again, which reloads PC and stays RESTART.
REQ-022 PC arithmetic SHALL be modulo 2^WORD_SIZE; all-ones + 1 wraps to 0.
REQ-023 Consumption and capture at the same edge SHALL both take effect; no instruction lost or duplicated.

Reset
REQ-024 While reset_n=1: PC=0, state=RESTART, o_pc=0, o_Idata=0, o_valid=0, skid cleared, o_readM=0, o_addr=0.
REQ-025 After reset_n falls, first rising edge SHALL enter REQ; o_readM=1 with o_addr=0 from then.
REQ-026 Reset asserted mid-request SHALL abandon it; late i_mem_ready ignored.

Configuration
REQ-027 With FETCH_COUNT_EN defined: SHALL add output o_num_inst (WORD_SIZE) counting instructions consumed (o_valid=1, hazard=0, no IF_flush), reset to 0, wrapping.
REQ-028 Without FETCH_COUNT_EN: port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-029 Reset release, i_mem_ready=1 always, data=addr*3 -> o_pc 1,2,3 on consecutive cycles, o_Idata 0,3,6, o_valid=1 continuously.
REQ-030 i_mem_ready pulses every 3rd cycle -> o_valid=1 one cycle per 3, bubbles between, no address skipped.
REQ-031 hazard=1 for 4 cycles while o_valid=1 and ready=1 -> HOLD entered, o_readM=0, outputs frozen; on release skid word presented next edge, sequence contiguous.
REQ-032 IF_flush with redirect_pc=16'h0040 during pending fetch at 0x0005 -> o_valid=0, one cycle o_readM=0, next request o_addr=0x0040, 0x0005 data never presented.
REQ-033 PC=16'hFFFF fetch -> o_pc=0, next o_addr=0; reset_n=1 mid-HOLD -> all outputs 0 asynchronously.
REQ-034 FETCH_COUNT_EN build, 10 instructions consumed with 2 flushed -> o_num_inst=10.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with one-entry skid buffer, flush/redirect, and registered IF_ID outputs.
// Optional FETCH_COUNT_EN adds o_num_inst, a count of consumed instructions.
module fetch_unit #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 hazard,
  input  logic                 IF_flush,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 o_readM,
  output logic [WORD_SIZE-1:0] o_addr,
  input  logic                 i_mem_ready,
  input  logic [WORD_SIZE-1:0] i_mem_data,
  output logic [WORD_SIZE-1:0] o_pc,
  output logic [WORD_SIZE-1:0] o_Idata,
  output logic                 o_valid
`ifdef FETCH_COUNT_EN
  ,
  output logic [WORD_SIZE-1:0] o_num_inst
`endif
);
  typedef enum logic [1:0] {S_REQ, S_HOLD, S_RESTART} state_t;
  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d, opc_q, opc_d, odata_q, odata_d;
  logic [WORD_SIZE-1:0] skid_pc_q, skid_pc_d, skid_data_q, skid_data_d;
  logic                 ovalid_q, ovalid_d;
  logic [WORD_SIZE-1:0] pc_inc;
  assign pc_inc  = pc_q + WORD_SIZE'(1);
  assign o_readM = state_q == S_REQ;
  assign o_addr  = pc_q;
  assign o_pc    = opc_q;
  assign o_Idata = odata_q;
  assign o_valid = ovalid_q;
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    opc_d       = opc_q;
    odata_d     = odata_q;
    ovalid_d    = ovalid_q;
    skid_pc_d   = skid_pc_q;
    skid_data_d = skid_data_q;
    if (IF_flush) begin
      pc_d     = redirect_pc;
      ovalid_d = 1'b0;
      state_d  = S_RESTART;
    end else begin
      case (state_q)
        S_REQ: begin
          if (i_mem_ready) begin
            pc_d = pc_inc;
            if (!ovalid_q || !hazard) begin
              odata_d  = i_mem_data;
              opc_d    = pc_inc;
              ovalid_d = 1'b1;
            end else begin
              skid_data_d = i_mem_data;
              skid_pc_d   = pc_inc;
              state_d     = S_HOLD;
            end
          end else if (!hazard) begin
            ovalid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (!hazard) begin
            odata_d  = skid_data_q;
            opc_d    = skid_pc_q;
            ovalid_d = 1'b1;
            state_d  = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q     <= S_RESTART;
      pc_q        <= '0;
      opc_q       <= '0;
      odata_q     <= '0;
      ovalid_q    <= 1'b0;
      skid_pc_q   <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      opc_q       <= opc_d;
      odata_q     <= odata_d;
      ovalid_q    <= ovalid_d;
      skid_pc_q   <= skid_pc_d;
      skid_data_q <= skid_data_d;
    end
  end
`ifdef FETCH_COUNT_EN
  logic [WORD_SIZE-1:0] num_q, num_d;
  assign num_d      = num_q + WORD_SIZE'(ovalid_q & ~hazard & ~IF_flush);
  assign o_num_inst = num_q;
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) num_q <= '0;
    else num_q <= num_d;
  end
`endif
endmodule
